// File: rtl/iaaa_pkg.sv
// Shared definitions for the instruction fetch stage and the microcode sequencer.
package iaaa_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 12;
  localparam int unsigned OPCODE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_END  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_JMPZ = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack bus: fetch unit is master, memory is slave.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 12
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               ack;

  modport master (output req, output addr, input rdata, input ack);
  modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: direct/deferred loads, post-capture increment with wrap, sticky end flag.
module pc_counter
  import iaaa_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              capture,
  input  logic [ADDR_W-1:0] cap_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              y
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              y_q, y_d;

  // Next PC: a load seen while a fetch is outstanding is parked until capture
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    y_d        = y_q;
    if (capture) begin
      if (pc_load)                  pc_d = pc_load_val;
      else if (pend_vld_q)          pc_d = pend_q;
      else if (cap_addr == LAST_ADDR) pc_d = '0;
      else                          pc_d = cap_addr + ADDR_W'(1);
      if (cap_addr == LAST_ADDR) y_d = 1'b1;
      pend_vld_d = 1'b0;
    end else if (pc_load) begin
      if (in_req) begin
        pend_d     = pc_load_val;
        pend_vld_d = 1'b1;
      end else begin
        pc_d = pc_load_val;
      end
    end
  end

  // PC state registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      y_q        <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      y_q        <= y_d;
    end
  end

  assign pc = pc_q;
  assign y  = y_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, imem req/ack handshake, instruction register.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import iaaa_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(8'hFF),
  parameter int unsigned       TIMEOUT   = 15
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     fetch,
  input  logic                     pc_load,
  input  logic [ADDR_W-1:0]        pc_load_val,
  instr_fetch_unit_if.master       imem,
  output logic [OPCODE_W-1:0]      ir_opcode,
  output logic [INSTR_W-OPCODE_W-1:0] ir_operand,
  output logic                     ir_valid,
  output logic                     busy,
  output logic [ADDR_W-1:0]        pc,
  output logic                     y,
  output logic                     fault
);

  localparam int unsigned OPND_W = INSTR_W - OPCODE_W;

  fetch_state_e          state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic [OPND_W-1:0]     opnd_q, opnd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ack_cap, to_cap, capture;

  assign ack_cap = (state_q == ST_REQ) && imem.ack;
  assign capture = ack_cap || to_cap;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // Ack watchdog: counts REQ cycles, restarts from zero on each entry into REQ
  always_comb begin
    cnt_d   = (state_q == ST_REQ) ? cnt_q + CNT_W'(1) : '0;
    to_cap  = (state_q == ST_REQ) && !imem.ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    fault_d = fault_q | to_cap;
  end

  // Watchdog registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign to_cap = 1'b0;
  assign fault  = 1'b0;
`endif

  // Fetch FSM next state and registered outputs
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch && !y) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = pc_load ? pc_load_val : pc;
        end
      end
      ST_REQ: begin
        if (capture) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          if (ack_cap) begin
            op_d   = imem.rdata[INSTR_W-1 -: OPCODE_W];
            opnd_d = imem.rdata[OPND_W-1:0];
          end else begin
            op_d   = OP_NOP;
            opnd_d = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch FSM registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      op_q    <= OP_NOP;
      opnd_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  pc_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc_counter (
    .clock       (clock),
    .rst_n       (rst_n),
    .in_req      (state_q == ST_REQ),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .capture     (capture),
    .cap_addr    (addr_q),
    .pc          (pc),
    .y           (y)
  );

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign ir_opcode  = op_q;
  assign ir_operand = opnd_q;
  assign ir_valid   = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (honours FETCH_TIMEOUT_EN if defined).
module tb_instr_fetch_unit;

  localparam int unsigned AW   = 8;
  localparam int unsigned IW   = 12;
  localparam int unsigned TO   = 15;
  localparam logic [7:0]  LAST = 8'hFF;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       fetch = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = 8'h00;
  logic [3:0] ir_opcode;
  logic [7:0] ir_operand;
  logic       ir_valid, busy, y, fault;
  logic [7:0] pc;

  always #5 clock = ~clock;

  instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .LAST_ADDR(LAST), .TIMEOUT(TO)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .fetch       (fetch),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .imem        (bus),
    .ir_opcode   (ir_opcode),
    .ir_operand  (ir_operand),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .pc          (pc),
    .y           (y),
    .fault       (fault)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_cap    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding fetch, deferred loads kept in a queue
  logic       m_req = 0, m_busy = 0, m_valid = 0, m_y = 0, m_fault = 0;
  logic [7:0] m_addr = 0, m_pc = 0, m_opnd = 0;
  logic [3:0] m_op = 0;
  int         m_wait = 0;
  logic [7:0] m_pend[$];

  always @(posedge clock or negedge rst_n) begin : model
    bit done_cycle;
    if (!rst_n) begin
      m_req = 0; m_busy = 0; m_valid = 0; m_y = 0; m_fault = 0;
      m_addr = 0; m_pc = 0; m_op = 0; m_opnd = 0; m_wait = 0;
      m_pend.delete();
    end else begin
      done_cycle = m_valid;
      m_valid = 0;
      if (m_req) begin
        m_wait++;
        if (bus.ack || (TIMEOUT_ON && m_wait == TO)) begin
          if (bus.ack) begin
            m_op = bus.rdata[11:8]; m_opnd = bus.rdata[7:0];
          end else begin
            m_op = 0; m_opnd = 0; m_fault = 1;
          end
          if (pc_load)                m_pc = pc_load_val;
          else if (m_pend.size() != 0) m_pc = m_pend[$];
          else if (m_addr == LAST)    m_pc = 8'h00;
          else                        m_pc = m_addr + 8'd1;
          if (m_addr == LAST) m_y = 1;
          m_pend.delete();
          m_req = 0; m_busy = 0; m_valid = 1;
        end else if (pc_load) begin
          m_pend.push_back(pc_load_val);
        end
      end else begin
        if (pc_load) m_pc = pc_load_val;
        if (fetch && !m_y && !done_cycle) begin
          m_req = 1; m_busy = 1; m_addr = m_pc; m_wait = 0;
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clock) begin
    chk("imem_req",   32'(bus.req),    32'(m_req));
    chk("imem_addr",  32'(bus.addr),   32'(m_addr));
    chk("pc",         32'(pc),         32'(m_pc));
    chk("y",          32'(y),          32'(m_y));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("ir_valid",   32'(ir_valid),   32'(m_valid));
    chk("ir_opcode",  32'(ir_opcode),  32'(m_op));
    chk("ir_operand", 32'(ir_operand), 32'(m_opnd));
    chk("fault",      32'(fault),      32'(m_fault));
    if (ir_valid === 1'b1) n_cap++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap0;
    bus.ack = 1'b0;
    bus.rdata = 12'h000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_opcode", 32'(ir_opcode), 32'h0);
    chk("rst_req", 32'(bus.req), 32'h0);

    // Zero-wait fetch of 12'h4A5 from address 0
    @(negedge clock); bus.rdata = 12'h4A5; fetch = 1;
    @(negedge clock); fetch = 0;
    chk("t1_req", 32'(bus.req), 32'h1);
    chk("t1_addr", 32'(bus.addr), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    bus.ack = 1;
    @(negedge clock); bus.ack = 0;
    chk("t1_valid", 32'(ir_valid), 32'h1);
    chk("t1_opcode", 32'(ir_opcode), 32'h4);
    chk("t1_operand", 32'(ir_operand), 32'hA5);
    chk("t1_pc", 32'(pc), 32'h1);
    chk("t1_busy_low", 32'(busy), 32'h0);
    @(negedge clock);
    chk("t1_valid_pulse", 32'(ir_valid), 32'h0);

    // Ack delayed 5 cycles with fetch pulses during the wait
    cap0 = n_cap;
    fetch = 1;
    @(negedge clock); fetch = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_hold", 32'(bus.req), 32'h1);
      chk("t2_addr_hold", 32'(bus.addr), 32'h1);
      chk("t2_busy_hold", 32'(busy), 32'h1);
      fetch = (i % 2 == 0);
      @(negedge clock);
    end
    fetch = 0; bus.ack = 1; bus.rdata = 12'h3C7;
    @(negedge clock); bus.ack = 0;
    chk("t2_opcode", 32'(ir_opcode), 32'h3);
    repeat (4) @(negedge clock);
    chk("t2_one_capture", 32'(n_cap - cap0), 32'h1);
    chk("t2_pc", 32'(pc), 32'h2);

    // pc_load and fetch in the same idle cycle
    pc_load = 1; pc_load_val = 8'h10; fetch = 1;
    @(negedge clock); pc_load = 0; fetch = 0;
    chk("t3_addr", 32'(bus.addr), 32'h10);
    chk("t3_pc_loaded", 32'(pc), 32'h10);
    bus.ack = 1; bus.rdata = 12'h0F0;
    @(negedge clock); bus.ack = 0;
    chk("t3_pc", 32'(pc), 32'h11);
    @(negedge clock);

    // Loads during REQ at address 3 are deferred; last one wins
    pc_load = 1; pc_load_val = 8'h03;
    @(negedge clock); pc_load = 0;
    chk("t4_pc_idle_load", 32'(pc), 32'h3);
    fetch = 1;
    @(negedge clock); fetch = 0;
    chk("t4_addr", 32'(bus.addr), 32'h3);
    pc_load = 1; pc_load_val = 8'h55;
    @(negedge clock); pc_load_val = 8'h20;
    @(negedge clock); pc_load = 0;
    chk("t4_pc_during_req", 32'(pc), 32'h3);
    bus.ack = 1; bus.rdata = 12'hF07;
    @(negedge clock); bus.ack = 0;
    chk("t4_pc_pending", 32'(pc), 32'h20);
    chk("t4_opcode", 32'(ir_opcode), 32'hF);
    @(negedge clock);

    // Back-to-back fetches with ack held high: one capture per 3 cycles
    cap0 = n_cap;
    fetch = 1; bus.ack = 1; bus.rdata = 12'h5C3;
    repeat (9) @(negedge clock);
    fetch = 0; bus.ack = 0;
    repeat (3) @(negedge clock);
    chk("t5_captures", 32'(n_cap - cap0), 32'h3);
    chk("t5_pc", 32'(pc), 32'h23);

    // Capture at LAST_ADDR wraps pc and sets y; y blocks further fetches
    pc_load = 1; pc_load_val = LAST;
    @(negedge clock); pc_load = 0; fetch = 1;
    @(negedge clock); fetch = 0;
    chk("t6_addr", 32'(bus.addr), 32'hFF);
    bus.ack = 1; bus.rdata = 12'h100;
    @(negedge clock); bus.ack = 0;
    chk("t6_pc_wrap", 32'(pc), 32'h0);
    chk("t6_y", 32'(y), 32'h1);
    @(negedge clock);
    fetch = 1;
    repeat (4) begin
      @(negedge clock);
      chk("t6_no_req", 32'(bus.req), 32'h0);
    end
    fetch = 0;
    pc_load = 1; pc_load_val = 8'h42;
    @(negedge clock); pc_load = 0;
    chk("t6_load_with_y", 32'(pc), 32'h42);
    chk("t6_y_sticky", 32'(y), 32'h1);

    // Asynchronous reset in the middle of REQ
    rst_n = 0;
    @(negedge clock); rst_n = 1;
    pc_load = 1; pc_load_val = 8'h07;
    @(negedge clock); pc_load = 0; fetch = 1;
    @(negedge clock); fetch = 0;
    chk("t7_req", 32'(bus.req), 32'h1);
    chk("t7_addr", 32'(bus.addr), 32'h7);
    cap0 = n_cap;
    @(negedge clock);
    #2 rst_n = 0;
    #1;
    chk("t7_req_async", 32'(bus.req), 32'h0);
    chk("t7_pc_async", 32'(pc), 32'h0);
    chk("t7_addr_async", 32'(bus.addr), 32'h0);
    chk("t7_busy_async", 32'(busy), 32'h0);
    chk("t7_y_async", 32'(y), 32'h0);
    @(negedge clock); rst_n = 1;
    repeat (2) @(negedge clock);
    chk("t7_no_capture", 32'(n_cap - cap0), 32'h0);

    // Memory never acks
    bus.rdata = 12'hABC;
    fetch = 1;
    @(negedge clock); fetch = 0;
    chk("t8_req", 32'(bus.req), 32'h1);
`ifdef FETCH_TIMEOUT_EN
    repeat (14) begin
      @(negedge clock);
      chk("t8_req_wait", 32'(bus.req), 32'h1);
    end
    @(negedge clock);
    chk("t8_to_valid", 32'(ir_valid), 32'h1);
    chk("t8_to_opcode", 32'(ir_opcode), 32'h0);
    chk("t8_to_operand", 32'(ir_operand), 32'h0);
    chk("t8_to_fault", 32'(fault), 32'h1);
    chk("t8_to_pc", 32'(pc), 32'h1);
    repeat (2) @(negedge clock);
    chk("t8_fault_sticky", 32'(fault), 32'h1);
`else
    repeat (100) @(negedge clock);
    chk("t8_req_still", 32'(bus.req), 32'h1);
    chk("t8_busy_still", 32'(busy), 32'h1);
    chk("t8_fault_zero", 32'(fault), 32'h0);
`endif
    rst_n = 0;
    @(negedge clock); rst_n = 1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the microcode sequencer. Owns the program counter, runs a req/ack handshake with instruction memory, and latches the fetched word into the instruction register. Drives the sequencer's 4-bit opcode input and the `y` end-of-program flag. Its `fetch` input is driven from the sequencer's PCD microcode bit.

## Interface
- `ADDR_W`, default 8: program counter and instruction-address width.
- `INSTR_W`, default 12: instruction word width; `[INSTR_W-1:INSTR_W-4]` is the opcode and `[INSTR_W-5:0]` is the operand.
- `LAST_ADDR`, default 8'hFF: highest valid program address.
- `TIMEOUT`, default 15: ack watchdog limit in cycles; used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch` in 1: fetch request, level-sampled; starts a fetch only when the unit is idle.
- `pc_load` in 1: load the PC (JMPZ taken).
- `pc_load_val` in ADDR_W: jump target.
- `imem_req` out 1: memory request.
- `imem_addr` out ADDR_W: memory address; stable while `imem_req` is high.
- `imem_rdata` in INSTR_W: memory read data; valid when `imem_ack` is high.
- `imem_ack` in 1: memory acknowledge.
- `ir_opcode` out 4: instruction-register opcode; feeds the sequencer's `IR_Out`.
- `ir_operand` out INSTR_W-4: instruction-register operand.
- `ir_valid` out 1: one-cycle pulse when a new word is captured.
- `busy` out 1: high from fetch acceptance until capture.
- `pc` out ADDR_W: current program counter.
- `y` out 1: sticky end-of-program flag.
- `fault` out 1: sticky timeout flag; tied to 0 without `FETCH_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ when `fetch` is high and `y` is low.
  - Set `imem_addr` = `pc`.
  - Set `imem_req` = 1.
  - Set `busy` = 1.
- REQ holds until `imem_ack` is sampled high. On that edge:
  - Capture the IR from `imem_rdata`.
  - Set `pc` = `imem_addr` + 1.
  - Drop `imem_req`.
  - Go to DONE.
- DONE: `ir_valid` = 1 for exactly one cycle, `busy` = 0, then return to IDLE.
- `pc_load` in IDLE: `pc` ← `pc_load_val` next edge.
- `pc_load` and `fetch` in the same IDLE cycle: the load applies first, and the fetch uses `pc_load_val` as its address.
- `pc_load` during REQ: the value is held in a pending register. At capture, `pc` ← pending value instead of addr+1. A later `pc_load` overwrites the pending value.
- `fetch` while `busy` is high: ignored, not queued.
- End of program:
  - If capture occurs at `imem_addr` == `LAST_ADDR`, `pc` wraps to 0 and `y` is set.
  - `y` clears only on reset.
  - While `y` = 1, no fetch is accepted.
  - `pc_load` still updates `pc` while `y` = 1.
- `imem_ack` outside REQ is ignored.
- Reset values:
  - `pc` = 0 and state = IDLE.
  - `imem_req`, `imem_addr`, `ir_valid`, `busy`, `y` and `fault` = 0.
  - `ir_opcode` = 4'b0000 (NOP) and `ir_operand` = 0.
- Reset mid-REQ: `imem_req` drops asynchronously, and no capture occurs.

## Timing
- `fetch` sampled in cycle N → `imem_req` high from N+1.
- Ack sampled at edge M (M ≥ N+1) → IR, `pc` and `ir_valid` are updated in cycle M+1, and `busy` is low in M+1.
- Minimum fetch latency is 2 cycles: acceptance to valid IR.
- A new `fetch` can be accepted in the cycle after `ir_valid`, i.e. back-to-back every 3 cycles with zero-wait memory.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An internal cycle counter runs in REQ.
  - If `TIMEOUT` cycles elapse without ack, capture NOP (opcode 0, operand 0) and set `fault`.
  - `pc` still advances by 1, and `ir_valid` pulses as on a normal capture.
  - The counter resets on every entry into REQ.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter is built.
  - REQ waits for ack indefinitely.
  - `fault` is constant 0.

## Structure
- Shared package `iaaa_pkg`:
  - opcode constants: NOP=4'h0, END=4'h1, …, JMPZ=4'hF.
  - the fetch FSM state enum.
  - default `ADDR_W`/`INSTR_W` constants.
- One natural sub-module: `pc_counter`. It holds the load/increment/wrap logic, the pending-load register and the `y` generation.

## Test plan
- Reset, then `fetch` with ack returned the cycle after req, `imem_rdata`=12'h4A5:
  - `imem_addr`=0.
  - `ir_opcode`=4, `ir_operand`=8'hA5, `ir_valid` for one cycle.
  - `pc`=1.
- Ack delayed by 5 cycles:
  - `imem_req` and `imem_addr` are stable for all 5 cycles.
  - `busy` stays high.
  - `fetch` pulses during the wait are ignored, giving exactly one capture.
- `pc_load`=8'h20 asserted during REQ at address 3: `pc`=8'h20 after capture, not 4.
- `pc`=`LAST_ADDR`, fetch completes:
  - `pc`=0 and `y`=1.
  - A subsequent `fetch` produces no `imem_req`.
- `FETCH_TIMEOUT_EN`, never ack:
  - After 15 cycles, `ir_opcode`=0, `fault`=1 and `pc`+1.
  - Without the macro, `imem_req` is still high after 100 cycles.
- `rst_n` asserted mid-REQ: `imem_req` drops immediately, all outputs return to reset values, and `pc`=0.
